// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Purpose:
//   This is the producer side of the operand-forwarding interface. It tracks the
//   destination register of the instructions in EX and MEM, and from that it
//   produces the forwarding selects used by the ID-stage operand mux.
//   It also detects load-use hazards. On a load-use hazard it stalls PC and
//   IF/ID for one cycle and injects a bubble into EX. A branch flush kills the
//   ID instruction. ext_stall freezes all of the tracking state.
//
// Ports:
//   clk, resetn            pipeline clock, asynchronous active-low reset
//   id_valid               ID stage holds a valid instruction
//   id_rs1, id_rs2         source register addresses of the ID instruction
//   id_rs1_used/_rs2_used  ID instruction actually reads that operand
//   id_rd, id_wen          destination of the ID instruction and its write enable
//   id_is_load             ID instruction is a load
//   flush                  taken branch resolved in EX, kill the ID instruction
//   ext_stall              memory wait, freeze the whole pipeline
//   fwd_ex_rs1/_rs2        operand takes EX_alu_result
//   fwd_mem_rs1/_rs2       operand takes MEM_dm_data
//   ld_stall               load-use hazard this cycle
//   stall_if_id            hold PC and the IF/ID register
//   bubble_ex              the ID/EX register loads a NOP
//   stall_cnt              load-use stall cycle count
//
// Build option:
//   FWD_HAZARD_PERF_EN     when this macro is defined, stall_cnt counts load-use
//                          stall cycles and wraps at 2^PERF_W. When it is not
//                          defined, stall_cnt is tied to zero.
//
// Tracked state:
//   stage | meaning
//   EX    | ex_valid, ex_rd, ex_wen, ex_load  : instruction now in EX
//   MEM   | mem_valid, mem_rd, mem_wen        : instruction now in MEM
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              fwd_ex_rs1,
  output logic              fwd_mem_rs1,
  output logic              fwd_ex_rs2,
  output logic              fwd_mem_rs2,
  output logic              ld_stall,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic [PERF_W-1:0] stall_cnt
);

  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_wen;
  logic              ex_load;

  logic              mem_valid;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_wen;

  logic              rs1_live;
  logic              rs2_live;
  logic              ex_hit_rs1;
  logic              ex_hit_rs2;
  logic              mem_hit_rs1;
  logic              mem_hit_rs2;
  logic              ex_accept;

  // r0 is hardwired to zero, so a producer that targets r0 never matches.
  assign ex_hit_rs1  = ex_valid  & ex_wen  & (ex_rd  == id_rs1) & (id_rs1 != '0);
  assign ex_hit_rs2  = ex_valid  & ex_wen  & (ex_rd  == id_rs2) & (id_rs2 != '0);
  assign mem_hit_rs1 = mem_valid & mem_wen & (mem_rd == id_rs1) & (id_rs1 != '0);
  assign mem_hit_rs2 = mem_valid & mem_wen & (mem_rd == id_rs2) & (id_rs2 != '0);

  assign rs1_live = id_valid & id_rs1_used;
  assign rs2_live = id_valid & id_rs2_used;

  // An EX hit masks any MEM hit, because the youngest producer wins.
  // If the EX producer is a load, its data does not exist yet, so neither
  // select fires for that operand. Instead ld_stall holds the reader for a
  // cycle, and on the next cycle the load is in MEM and is forwarded from there.
  assign fwd_ex_rs1  = rs1_live & ex_hit_rs1 & ~ex_load;
  assign fwd_ex_rs2  = rs2_live & ex_hit_rs2 & ~ex_load;
  assign fwd_mem_rs1 = rs1_live & mem_hit_rs1 & ~ex_hit_rs1;
  assign fwd_mem_rs2 = rs2_live & mem_hit_rs2 & ~ex_hit_rs2;

  // flush has priority: a killed instruction never stalls.
  assign ld_stall = id_valid & ~flush & ex_load &
                    ((rs1_live & ex_hit_rs1) | (rs2_live & ex_hit_rs2));

  assign stall_if_id = ld_stall | ext_stall;
  assign bubble_ex   = (ld_stall | flush) & ~ext_stall;

  assign ex_accept = id_valid & ~flush & ~ld_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_wen    <= 1'b0;
      ex_load   <= 1'b0;
      mem_valid <= 1'b0;
      mem_rd    <= '0;
      mem_wen   <= 1'b0;
    end else if (!ext_stall) begin
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_wen   <= ex_wen;
      // On a bubble the EX fields are cleared, so the NOP cannot match anything.
      ex_valid  <= ex_accept;
      ex_rd     <= ex_accept ? id_rd : '0;
      ex_wen    <= ex_accept & id_wen;
      ex_load   <= ex_accept & id_is_load;
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (ld_stall && !ext_stall) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int PERF_W = 32;

  logic              clk;
  logic              resetn;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_wen;
  logic              id_is_load;
  logic              flush;
  logic              ext_stall;
  logic              fwd_ex_rs1;
  logic              fwd_mem_rs1;
  logic              fwd_ex_rs2;
  logic              fwd_mem_rs2;
  logic              ld_stall;
  logic              stall_if_id;
  logic              bubble_ex;
  logic [PERF_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  fwd_hazard_ctrl #(.REG_AW(REG_AW), .PERF_W(PERF_W)) dut (
    .clk(clk), .resetn(resetn),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
    .flush(flush), .ext_stall(ext_stall),
    .fwd_ex_rs1(fwd_ex_rs1), .fwd_mem_rs1(fwd_mem_rs1),
    .fwd_ex_rs2(fwd_ex_rs2), .fwd_mem_rs2(fwd_mem_rs2),
    .ld_stall(ld_stall), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
    .stall_cnt(stall_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: a two-entry list of in-flight producers.
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              w;
    logic              l;
  } ins_t;

  ins_t              m_ex;
  ins_t              m_mem;
  logic [PERF_W-1:0] m_cnt;

  function automatic bit writes(ins_t p, logic [REG_AW-1:0] rs);
    return p.v && p.w && (p.rd == rs) && (rs != 0);
  endfunction

  function automatic bit m_stall();
    if (!id_valid || flush || !m_ex.l) return 0;
    return (id_rs1_used && writes(m_ex, id_rs1)) || (id_rs2_used && writes(m_ex, id_rs2));
  endfunction

  // Select for one operand: 2 = from EX, 1 = from MEM, 0 = none.
  function automatic int m_src(logic used, logic [REG_AW-1:0] rs);
    if (!id_valid || !used) return 0;
    if (writes(m_ex, rs)) return m_ex.l ? 0 : 2;
    if (writes(m_mem, rs)) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ex  <= '0;
      m_mem <= '0;
      m_cnt <= '0;
    end else if (!ext_stall) begin
      m_mem <= m_ex;
      if (id_valid && !flush && !m_stall())
        m_ex <= '{v: 1'b1, rd: id_rd, w: id_wen, l: id_is_load};
      else
        m_ex <= '0;
      if (m_stall()) m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      int s1;
      int s2;
      bit st;
      logic [PERF_W-1:0] ec;
      s1 = m_src(id_rs1_used, id_rs1);
      s2 = m_src(id_rs2_used, id_rs2);
      st = m_stall();
`ifdef FWD_HAZARD_PERF_EN
      ec = m_cnt;
`else
      ec = '0;
`endif
      check("fwd_ex_rs1",  fwd_ex_rs1,  s1 == 2);
      check("fwd_mem_rs1", fwd_mem_rs1, s1 == 1);
      check("fwd_ex_rs2",  fwd_ex_rs2,  s2 == 2);
      check("fwd_mem_rs2", fwd_mem_rs2, s2 == 1);
      check("ld_stall",    ld_stall,    st);
      check("stall_if_id", stall_if_id, st || ext_stall);
      check("bubble_ex",   bubble_ex,   (st || flush) && !ext_stall);
      check("stall_cnt",   stall_cnt,   ec);
    end
  end

  task automatic cyc(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic w, input logic ld, input logic fl, input logic es);
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd = rd; id_wen = w; id_is_load = ld; flush = fl; ext_stall = es;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {fwd_ex_rs1, fwd_mem_rs1, fwd_ex_rs2, fwd_mem_rs2,
                 ld_stall, stall_if_id, bubble_ex}, 0);
    check({name, "_cnt"}, stall_cnt, 0);
  endtask

  initial begin
    resetn = 0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_wen = 0; id_is_load = 0; flush = 0; ext_stall = 0;
    #1;
    cmp_en = 1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    resetn = 1;

    // EX forward
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    cyc(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    check("t1_fwd_ex_rs1", fwd_ex_rs1, 1);
    check("t1_fwd_mem_rs1", fwd_mem_rs1, 0);
    check("t1_ld_stall", ld_stall, 0);

    // youngest producer wins, then MEM forward
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    cyc(1, 0, 7, 0, 1, 0, 0, 0, 0, 0);
    check("t2_fwd_ex_rs2", fwd_ex_rs2, 1);
    check("t2_fwd_mem_rs2", fwd_mem_rs2, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    cyc(1, 0, 7, 0, 1, 0, 0, 0, 0, 0);
    check("t2_mem_fwd_ex_rs2", fwd_ex_rs2, 0);
    check("t2_mem_fwd_mem_rs2", fwd_mem_rs2, 1);

    // load-use
    cyc(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    cyc(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    check("t3_ld_stall", ld_stall, 1);
    check("t3_stall_if_id", stall_if_id, 1);
    check("t3_bubble_ex", bubble_ex, 1);
    check("t3_fwd_ex_rs1", fwd_ex_rs1, 0);
    cyc(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    check("t3_next_fwd_mem_rs1", fwd_mem_rs1, 1);
    check("t3_next_ld_stall", ld_stall, 0);
`ifdef FWD_HAZARD_PERF_EN
    check("t3_stall_cnt", stall_cnt, 1);
`else
    check("t3_stall_cnt", stall_cnt, 0);
`endif

    // r0 and unused operand
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    check_all_zero("t4_r0");
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    check("t4_r0_load_stall", ld_stall, 0);
    cyc(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    cyc(1, 1, 4, 1, 0, 0, 0, 0, 0, 0);
    check("t4_unused_rs2", {fwd_ex_rs2, fwd_mem_rs2, ld_stall}, 0);

    // flush beats load-use
    cyc(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
    cyc(1, 6, 0, 1, 0, 0, 0, 0, 1, 0);
    check("t5_ld_stall", ld_stall, 0);
    check("t5_bubble_ex", bubble_ex, 1);
    cyc(1, 6, 0, 1, 0, 0, 0, 0, 0, 0);
    check("t5_next_fwd_ex_rs1", fwd_ex_rs1, 0);
    check("t5_next_ld_stall", ld_stall, 0);

    // ext_stall hold
    cyc(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
    repeat (3) begin
      cyc(1, 8, 0, 1, 0, 0, 0, 0, 0, 1);
      check("t6_hold_fwd_ex_rs1", fwd_ex_rs1, 1);
      check("t6_hold_stall_if_id", stall_if_id, 1);
      check("t6_hold_bubble_ex", bubble_ex, 0);
    end
    cyc(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
    check("t6_after_fwd_ex_rs1", fwd_ex_rs1, 1);

    // reset mid-sequence
    cyc(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
    cyc(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
    check("t6_pre_reset_stall", ld_stall, 1);
    resetn = 0;
    #1;
    check_all_zero("t6_reset");
    #1;
    resetn = 1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 8,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 6) == 0);
      if ($urandom_range(0, 99) == 0) begin
        flush = 0;
        ext_stall = 0;
        resetn = 0;
        #1;
        check_all_zero("rand_reset");
        #1;
        resetn = 1;
      end
    end

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Producer side of the operand-forwarding interface. Tracks destination-register info for the instructions in the EX and MEM stages. Generates the forwardEX/forwardMEM select pair that the ID-stage operand mux consumes for rs1 and for rs2. Also detects load-use hazards, issues a one-cycle stall plus an EX bubble, and honours branch flush and external memory stall.

Parameters:
- REG_AW, 5, register address width (32 GPRs; r0 is hardwired zero).
- PERF_W, 32, width of the stall performance counter (only used with the optional feature).

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1  in  REG_AW  rs1 address of the ID instruction.
- id_rs2  in  REG_AW  rs2 address of the ID instruction.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- id_rd  in  REG_AW  destination address of the ID instruction.
- id_wen  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- flush  in  1  taken branch resolved in EX; kill the ID instruction.
- ext_stall  in  1  memory wait; freeze the whole pipeline.
- fwd_ex_rs1  out  1  rs1 takes EX_alu_result.
- fwd_mem_rs1  out  1  rs1 takes MEM_dm_data.
- fwd_ex_rs2  out  1  rs2 takes EX_alu_result.
- fwd_mem_rs2  out  1  rs2 takes MEM_dm_data.
- ld_stall  out  1  load-use hazard this cycle.
- stall_if_id  out  1  hold PC and the IF/ID register.
- bubble_ex  out  1  the ID/EX register loads a NOP.
- stall_cnt  out  PERF_W  stall cycle count (optional feature only).

Behaviour:
- Internal state per stage:
  - EX: ex_valid, ex_rd, ex_wen, ex_load.
  - MEM: mem_valid, mem_rd, mem_wen.
- Reset (async, resetn=0): all valid and wen bits = 0, rd = 0, stall_cnt = 0. All outputs therefore read 0 after reset.
- Update on the rising edge of clk, only when ext_stall=0:
  - MEM stage <= EX stage (valid, rd, wen).
  - EX stage <= ID fields when id_valid & ~flush & ~ld_stall; otherwise a bubble (ex_valid=0, ex_wen=0).
- ext_stall=1: all state holds. flush and ID inputs are ignored that cycle; the source must hold flush until ext_stall drops.
- Define ex_hit(rs) = ex_valid & ex_wen & (ex_rd==rs) & (rs!=0). Define mem_hit(rs) = mem_valid & mem_wen & (mem_rd==rs) & (rs!=0).
- Forward selects are combinational from state and ID inputs, zero latency. For x in {rs1, rs2}:
  - fwd_ex_x = id_valid & id_x_used & ex_hit(id_x) & ~ex_load.
  - fwd_mem_x = id_valid & id_x_used & mem_hit(id_x) & ~ex_hit(id_x).
  - The two selects are never both 1. The youngest producer (EX) wins.
- ld_stall = id_valid & ~flush & ex_load & ((id_rs1_used & ex_hit(id_rs1)) | (id_rs2_used & ex_hit(id_rs2))).
  - While ld_stall=1, both fwd_ex for the hit operand and fwd_mem are 0 for that operand.
  - On the next cycle the load has moved to MEM, so fwd_mem asserts.
- stall_if_id = ld_stall | ext_stall.
- bubble_ex = (ld_stall | flush) & ~ext_stall.
- Priority: flush > ld_stall. A flushed instruction never stalls, and the bubble is inserted.
- A load-use hazard always costs exactly 1 stall cycle, plus any ext_stall cycles that overlap.
- A write to r0 is never forwarded and never causes a stall.
- Reset asserted mid-stall: state clears immediately and ld_stall drops asynchronously.

Optional Feature:
- Macro FWD_HAZARD_PERF_EN.
- Defined: stall_cnt increments by 1 on each clk edge where ld_stall=1 & ext_stall=0. It wraps at 2^PERF_W and resets to 0.
- Undefined: no counter register; stall_cnt is tied to 0.

Test Plan:
- EX forward: cycle N ID "add r5" (wen, rd=5), cycle N+1 ID reads rs1=5 -> fwd_ex_rs1=1, fwd_mem_rs1=0, ld_stall=0.
- MEM forward and priority: r7 written by two consecutive instructions, then read by rs2 -> fwd_ex_rs2=1 only. With one independent instruction in between -> fwd_mem_rs2=1 only.
- Load-use: "ld r3" followed by a reader of rs1=3 -> ld_stall=1, stall_if_id=1, bubble_ex=1 for 1 cycle. The next cycle gives fwd_mem_rs1=1, ld_stall=0. With the macro defined, stall_cnt=1.
- r0 and unused operand: producer rd=0, or id_rs2_used=0 with a matching address -> all fwd and stall outputs 0.
- Flush versus load-use: load in EX, dependent instruction in ID, flush=1 -> ld_stall=0, bubble_ex=1. The next cycle EX holds a bubble (no forwards).
- ext_stall hold and reset: ext_stall=1 for 3 cycles during an EX-forward case -> outputs are constant and state is unchanged. resetn pulsed low mid-sequence -> all outputs 0 immediately.
